dcpu_prefetch: RTL and testbench

Instruction prefetch queue between the memory bus and the dcpu fetch/decode logic. It issues 32-bit read cycles on the bus and splits each returned word into two 16-bit instruction halfwords. The halfwords sit in a small FIFO, each tagged with its byte address, and the CPU consumes them through a valid/ready handshake. A flush input redirects fetching after jumps, interrupts or reset of the program counter.

---
 rtl/dcpu_prefetch_if.sv | 21 ++
 rtl/dcpu_prefetch.sv | 206 ++++++++++++++++++++
 tb/tb_dcpu_prefetch.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcpu_prefetch_if.sv
// Bus-side interface of the dcpu instruction prefetch queue.
// master: the prefetcher issuing read cycles; slave: the memory answering them.
interface dcpu_prefetch_if;
    logic        cyc;
    logic [3:0]  stb;
    logic [31:0] addr;
    logic [31:0] dat_w;
    logic        we;
    logic        ack;
    logic [31:0] dat_r;

    modport master (
        output cyc, stb, addr, dat_w, we,
        input  ack, dat_r
    );

    modport slave (
        input  cyc, stb, addr, dat_w, we,
        output ack, dat_r
    );
endinterface

// File: rtl/dcpu_prefetch.sv
// dcpu instruction prefetch queue.
// Fetches 32-bit words, splits them into two 16-bit halfwords tagged with their
// byte address, and hands them to the CPU through a valid/ready handshake.
// Optional feature: define DCPU_PREFETCH_BYPASS_EN to present the first halfword
// combinationally in the ack cycle when the queue is empty.
module dcpu_prefetch #(
    parameter int unsigned DEPTH = 4
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    input  logic            i_flush,
    input  logic [15:0]     i_flush_pc,
    output logic            o_valid,
    output logic [15:0]     o_instr,
    output logic [15:0]     o_pc,
    input  logic            i_ready,
    dcpu_prefetch_if.master bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_DISCARD
    } state_t;

    state_t        state;
    logic [15:0]   fetch_pc;
    logic          cyc_q;
    logic [3:0]    stb_q;
    logic [31:0]   addr_q;

    logic [15:0]   q_instr [DEPTH];
    logic [15:0]   q_pc    [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [PW-1:0] wptr_p1;
    logic [PW-1:0] count;
    logic          q_valid;
    logic [15:0]   head_instr;
    logic [15:0]   head_pc;

    logic [15:0]   flush_pc_even;
    logic [15:0]   issue_pc;
    logic [PW:0]   need_total;
    logic          room;
    logic          ack_req;
    logic          has_second;
    logic          skip_first;
    logic          pop;
    logic [15:0]   first_instr;
    logic [15:0]   second_instr;
    logic [15:0]   second_pc;
    logic          wr_a_en;
    logic          wr_b_en;
    logic [15:0]   wr_a_instr;
    logic [15:0]   wr_a_pc;
    logic          unused_flush_lsb;

    assign unused_flush_lsb = i_flush_pc[0];
    assign flush_pc_even    = {i_flush_pc[15:1], 1'b0};
    assign issue_pc         = i_flush ? flush_pc_even : fetch_pc;

    assign count      = wptr - rptr;
    assign q_valid    = (count != '0);
    assign wptr_p1    = wptr + PW'(1);
    assign head_instr = q_instr[rptr[AW-1:0]];
    assign head_pc    = q_pc[rptr[AW-1:0]];

    // Only one request is ever outstanding, so reserving its slots at issue
    // time reduces to checking free space against this word's halfword count.
    assign need_total = {1'b0, count} + (fetch_pc[1] ? (PW+1)'(1) : (PW+1)'(2));
    assign room       = (need_total <= (PW+1)'(DEPTH));

    assign ack_req      = (state == ST_REQ) && bus.ack && !i_flush;
    assign has_second   = !fetch_pc[1];
    assign first_instr  = fetch_pc[1] ? bus.dat_r[15:0] : bus.dat_r[31:16];
    assign second_instr = bus.dat_r[15:0];
    assign second_pc    = fetch_pc + 16'd2;
    assign pop          = q_valid && i_ready && !i_flush;

`ifdef DCPU_PREFETCH_BYPASS_EN
    logic byp_valid;

    assign byp_valid  = ack_req && !q_valid;
    assign skip_first = byp_valid && i_ready;
    assign o_valid    = q_valid || byp_valid;
    assign o_instr    = byp_valid ? first_instr : head_instr;
    assign o_pc       = byp_valid ? fetch_pc    : head_pc;
`else
    assign skip_first = 1'b0;
    assign o_valid    = q_valid;
    assign o_instr    = head_instr;
    assign o_pc       = head_pc;
`endif

    assign bus.cyc   = cyc_q;
    assign bus.stb   = stb_q;
    assign bus.addr  = addr_q;
    assign bus.dat_w = '0;
    assign bus.we    = 1'b0;

    // Select which halfwords of an acknowledged word land in the queue.
    always_comb begin
        wr_a_en    = 1'b0;
        wr_b_en    = 1'b0;
        wr_a_instr = first_instr;
        wr_a_pc    = fetch_pc;
        if (ack_req) begin
            if (skip_first) begin
                wr_a_en    = has_second;
                wr_a_instr = second_instr;
                wr_a_pc    = second_pc;
            end else begin
                wr_a_en = 1'b1;
                wr_b_en = has_second;
            end
        end
    end

    // Halfword FIFO: up to two pushes and one pop per cycle; flush empties it.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wptr <= '0;
            rptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                q_instr[i] <= '0;
                q_pc[i]    <= '0;
            end
        end else if (i_flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_a_en) begin
                q_instr[wptr[AW-1:0]] <= wr_a_instr;
                q_pc[wptr[AW-1:0]]    <= wr_a_pc;
            end
            if (wr_b_en) begin
                q_instr[wptr_p1[AW-1:0]] <= second_instr;
                q_pc[wptr_p1[AW-1:0]]    <= second_pc;
            end
            wptr <= wptr + PW'(wr_a_en) + PW'(wr_b_en);
            if (pop) begin
                rptr <= rptr + PW'(1);
            end
        end
    end

    // Bus request FSM with registered cyc/stb/addr and the fetch pointer.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state    <= ST_IDLE;
            fetch_pc <= '0;
            cyc_q    <= 1'b0;
            stb_q    <= '0;
            addr_q   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_flush) begin
                        fetch_pc <= flush_pc_even;
                    end
                    if (i_flush || room) begin
                        state  <= ST_REQ;
                        cyc_q  <= 1'b1;
                        stb_q  <= '1;
                        addr_q <= {16'h0000, issue_pc[15:2], 2'b00};
                    end
                end
                ST_REQ: begin
                    if (i_flush) begin
                        fetch_pc <= flush_pc_even;
                        if (bus.ack) begin
                            state <= ST_IDLE;
                            cyc_q <= 1'b0;
                            stb_q <= '0;
                        end else begin
                            state <= ST_DISCARD;
                        end
                    end else if (bus.ack) begin
                        fetch_pc <= {fetch_pc[15:2] + 14'd1, 2'b00};
                        state    <= ST_IDLE;
                        cyc_q    <= 1'b0;
                        stb_q    <= '0;
                    end
                end
                ST_DISCARD: begin
                    if (i_flush) begin
                        fetch_pc <= flush_pc_even;
                    end
                    if (bus.ack) begin
                        state <= ST_IDLE;
                        cyc_q <= 1'b0;
                        stb_q <= '0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cyc_q <= 1'b0;
                    stb_q <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dcpu_prefetch.sv
// Self-checking bench for dcpu_prefetch: memory model on the bus, scoreboards
// of expected request addresses and expected (pc, instr) halfwords.
`timescale 1ns/1ps
module tb_dcpu_prefetch;
    logic        i_clk = 1'b0;
    logic        i_reset_n;
    logic        i_flush;
    logic [15:0] i_flush_pc;
    logic        o_valid;
    logic [15:0] o_instr;
    logic [15:0] o_pc;
    logic        i_ready;

    dcpu_prefetch_if bus ();

    dcpu_prefetch #(.DEPTH(4)) dut (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_flush    (i_flush),
        .i_flush_pc (i_flush_pc),
        .o_valid    (o_valid),
        .o_instr    (o_instr),
        .o_pc       (o_pc),
        .i_ready    (i_ready),
        .bus        (bus)
    );

    always #5 i_clk = ~i_clk;

`ifdef DCPU_PREFETCH_BYPASS_EN
    localparam logic BYPASS = 1'b1;
`else
    localparam logic BYPASS = 1'b0;
`endif

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] instr;
    } hw_t;

    hw_t         exp_data[$];
    logic [31:0] exp_addr[$];
    logic [31:0] ovr [logic [15:0]];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned n_req    = 0;
    int unsigned ack_delay = 0;
    logic        cyc_prev = 1'b0;
    logic        got;
    hw_t         mon_e;

    task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
        n_checks++;
        if (got_v !== exp_v)
            $display("FAIL %s: got %h expected %h", tag, got_v, exp_v);
        else
            n_pass++;
    endtask

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        if (ovr.exists(a))
            return ovr[a];
        return {a + 16'h1000, a + 16'h1002};
    endfunction

    task automatic tick(input int unsigned n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic push_hw(input logic [15:0] pc, input logic [15:0] instr);
        hw_t e;
        e.pc    = pc;
        e.instr = instr;
        exp_data.push_back(e);
    endtask

    task automatic push_def(input logic [15:0] pc);
        push_hw(pc, pc + 16'h1000);
    endtask

    task automatic do_reset();
        @(posedge i_clk);
        #1;
        i_reset_n  = 1'b0;
        i_ready    = 1'b0;
        i_flush    = 1'b0;
        i_flush_pc = '0;
        #1;
        check("rst_valid", 32'(o_valid), 32'(0));
        check("rst_instr", 32'(o_instr), 32'(0));
        check("rst_pc",    32'(o_pc),    32'(0));
        check("rst_cyc",   32'(bus.cyc), 32'(0));
        check("rst_stb",   32'(bus.stb), 32'(0));
        check("rst_addr",  bus.addr,     32'(0));
        exp_data.delete();
        exp_addr.delete();
        ack_delay = 0;
        tick(3);
        n_req = 0;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 80 && (exp_data.size() != 0 || exp_addr.size() != 0); i++)
            tick(1);
        check({tag, "_data_left"}, 32'(exp_data.size()), 32'(0));
        check({tag, "_addr_left"}, 32'(exp_addr.size()), 32'(0));
    endtask

    // Memory: acks a read ack_delay cycles after cyc is seen, one-cycle ack.
    initial begin
        int unsigned wait_cnt;
        wait_cnt  = 0;
        bus.ack   = 1'b0;
        bus.dat_r = '0;
        forever begin
            @(posedge i_clk);
            #1;
            if (!i_reset_n || bus.ack) begin
                bus.ack  = 1'b0;
                wait_cnt = 0;
            end else if (bus.cyc) begin
                if (wait_cnt < ack_delay) begin
                    wait_cnt++;
                end else begin
                    bus.ack   = 1'b1;
                    bus.dat_r = mem_word(bus.addr[15:0]);
                    wait_cnt  = 0;
                end
            end
        end
    end

    // Monitor: new requests against exp_addr, accepted halfwords against exp_data.
    initial begin
        forever begin
            @(negedge i_clk);
            if (!i_reset_n) begin
                cyc_prev = 1'b0;
            end else begin
                if (bus.cyc && !cyc_prev) begin
                    n_req++;
                    check("req_stb", 32'(bus.stb), 32'h0000_000F);
                    check("req_we",  32'(bus.we),  32'(0));
                    if (exp_addr.size() != 0)
                        check("req_addr", bus.addr, exp_addr.pop_front());
                end
                cyc_prev = bus.cyc;
                if (o_valid && i_ready && !i_flush && exp_data.size() != 0) begin
                    mon_e = exp_data.pop_front();
                    check("out_pc",    32'(o_pc),    32'(mon_e.pc));
                    check("out_instr", 32'(o_instr), 32'(mon_e.instr));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish within 500us");
        $fatal(1, "timeout");
    end

    initial begin
        i_reset_n  = 1'b0;
        i_ready    = 1'b0;
        i_flush    = 1'b0;
        i_flush_pc = '0;

        // Basic fetch after reset with word 0 = 0x1234ABCD.
        do_reset();
        ovr[16'h0000] = 32'h1234ABCD;
        ovr[16'h0010] = 32'h11112222;
        exp_addr.push_back(32'h0);
        exp_addr.push_back(32'h4);
        push_hw(16'h0000, 16'h1234);
        push_hw(16'h0002, 16'hABCD);
        push_def(16'h0004);
        push_def(16'h0006);
        i_ready   = 1'b1;
        i_reset_n = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge i_clk);
            got = bus.ack;
        end
        check("ack_seen", 32'(got), 32'(1));
        check("valid_at_ack", 32'(o_valid), 32'(BYPASS));
        @(negedge i_clk);
        check("valid_after_ack", 32'(o_valid), 32'(1));
        wait_drain("t1");

        // Back-pressure: queue fills after two words, refills only with room for a full word.
        do_reset();
        exp_addr.push_back(32'h0);
        exp_addr.push_back(32'h4);
        i_reset_n = 1'b1;
        tick(20);
        check("req_when_full", 32'(n_req), 32'(2));
        push_hw(16'h0000, 16'h1234);
        i_ready = 1'b1;
        tick(1);
        i_ready = 1'b0;
        tick(10);
        check("req_after_pop1", 32'(n_req), 32'(2));
        push_hw(16'h0002, 16'hABCD);
        exp_addr.push_back(32'h8);
        i_ready = 1'b1;
        tick(1);
        i_ready = 1'b0;
        tick(10);
        check("req_after_pop2", 32'(n_req), 32'(3));
        check("t2_data_left", 32'(exp_data.size()), 32'(0));
        check("t2_addr_left", 32'(exp_addr.size()), 32'(0));

        // Flush from IDLE to an odd halfword address (bit 0 set, ignored).
        exp_addr.push_back(32'h10);
        exp_addr.push_back(32'h14);
        push_hw(16'h0012, 16'h2222);
        push_def(16'h0014);
        push_def(16'h0016);
        i_flush_pc = 16'h0013;
        i_flush    = 1'b1;
        tick(1);
        i_flush = 1'b0;
        @(negedge i_clk);
        check("valid_after_flush", 32'(o_valid), 32'(0));
        tick(1);
        i_ready = 1'b1;
        wait_drain("t3");

        // Flush during a slow request: cycle held, stale data dropped.
        ack_delay = 3;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge i_clk);
            got = bus.cyc && !bus.ack;
        end
        check("slow_req_seen", 32'(got), 32'(1));
        tick(1);
        i_ready = 1'b0;
        exp_addr.delete();
        exp_data.delete();
        exp_addr.push_back(32'h40);
        push_def(16'h0040);
        push_def(16'h0042);
        i_flush_pc = 16'h0040;
        i_flush    = 1'b1;
        tick(1);
        i_flush = 1'b0;
        @(negedge i_clk);
        check("discard_cyc",   32'(bus.cyc), 32'(1));
        check("discard_valid", 32'(o_valid), 32'(0));
        tick(1);
        ack_delay = 0;
        i_ready   = 1'b1;
        wait_drain("t4");

        // Address wrap from 0xFFFC to 0x0000.
        tick(1);
        i_ready = 1'b0;
        tick(10);
        exp_addr.delete();
        exp_data.delete();
        ovr[16'h0000] = 32'hAAAA5555;
        exp_addr.push_back(32'hFFFC);
        exp_addr.push_back(32'h0000);
        push_def(16'hFFFC);
        push_def(16'hFFFE);
        push_hw(16'h0000, 16'hAAAA);
        push_hw(16'h0002, 16'h5555);
        i_flush_pc = 16'hFFFC;
        i_flush    = 1'b1;
        tick(1);
        i_flush = 1'b0;
        i_ready = 1'b1;
        wait_drain("t5");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
